axi4lite_regbank: RTL

Parametrised AXI4-Lite slave exposing a bank of `NREGS` read/write control registers, each `DATA_W` bits wide, as flat parallel outputs. It is the generalised successor of the fixed two-register AXI4 word slave. It adds:
- configurable register count and data width
- byte-strobe writes
- decode-error responses for unmapped addresses
- per-register write pulses
- selectable write/read pipeline stages

It sits between the AXI interconnect and control logic that consumes static configuration words.

---
 rtl/axi4lite_regbank.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave exposing NREGS read/write configuration registers as flat parallel outputs,
// with byte strobes, DECERR for unmapped indices and optional write/read pipeline stages.
module axi4lite_regbank #(
    parameter int NREGS   = 4,
    parameter int DATA_W  = 32,
    parameter int WR_PIPE = 1,
    parameter int RD_PIPE = 1,
    localparam int BYTES  = DATA_W / 8,
    localparam int LSB    = $clog2(BYTES),
    localparam int IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int ADDR_W = LSB + IDX_W
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_W-1:LSB]     awaddr,
    input  logic [2:0]              awprot,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [BYTES-1:0]        wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_W-1:LSB]     araddr,
    input  logic [2:0]              arprot,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_W-1:0]       rdata,
    output logic [1:0]              rresp,
    output logic [NREGS*DATA_W-1:0] regs_o,
    output logic [NREGS-1:0]        wr_strobe_o
);
    localparam logic [IDX_W:0] NREGS_C     = (IDX_W + 1)'(NREGS);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_DECERR = 2'b11;

    logic                    aw_set_q, aw_set_d, w_set_q, w_set_d, wr_done_q, wr_done_d;
    logic [IDX_W-1:0]        waddr_q, waddr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [BYTES-1:0]        wstrb_q, wstrb_d;
    logic                    wreq_p1_q, wreq_p1_d;
    logic [IDX_W-1:0]        widx_p1_q, widx_p1_d;
    logic [DATA_W-1:0]       wdata_p1_q, wdata_p1_d;
    logic [BYTES-1:0]        wstrb_p1_q, wstrb_p1_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [NREGS*DATA_W-1:0] regs_q, regs_d;

    logic                    ar_set_q, ar_set_d, rd_done_q, rd_done_d;
    logic [IDX_W-1:0]        raddr_q, raddr_d;
    logic                    rack_p1_q, rack_p1_d;
    logic [DATA_W-1:0]       rdata_p1_q, rdata_p1_d;
    logic [1:0]              rresp_p1_q, rresp_p1_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;

    logic                    aw_hs, w_hs, b_hs, wr_req;
    logic                    cm_vld;
    logic [IDX_W-1:0]        cm_idx;
    logic [DATA_W-1:0]       cm_data;
    logic [BYTES-1:0]        cm_strb;
    logic [NREGS-1:0]        wr_strobe;
    logic                    ar_hs, r_hs, rd_req;
    logic [DATA_W-1:0]       rd_word;
    logic [1:0]              rd_resp;
    logic                    ra_vld;
    logic [DATA_W-1:0]       ra_data;
    logic [1:0]              ra_resp;

    logic unused_prot;
    assign unused_prot = ^{awprot, arprot};

    always_comb begin
        // Write capture: flags stay set until the B handshake, so only one write is in flight.
        aw_hs     = awvalid & ~aw_set_q;
        w_hs      = wvalid & ~w_set_q;
        b_hs      = bvalid_q & bready;
        wr_req    = aw_set_q & w_set_q & ~wr_done_q;
        aw_set_d  = (aw_set_q | aw_hs) & ~b_hs;
        w_set_d   = (w_set_q | w_hs) & ~b_hs;
        wr_done_d = (wr_done_q | wr_req) & ~b_hs;
        waddr_d   = aw_hs ? awaddr : waddr_q;
        wdata_d   = w_hs ? wdata : wdata_q;
        wstrb_d   = w_hs ? wstrb : wstrb_q;

        wreq_p1_d  = wr_req;
        widx_p1_d  = waddr_q;
        wdata_p1_d = wdata_q;
        wstrb_p1_d = wstrb_q;

        cm_vld  = (WR_PIPE != 0) ? wreq_p1_q  : wr_req;
        cm_idx  = (WR_PIPE != 0) ? widx_p1_q  : waddr_q;
        cm_data = (WR_PIPE != 0) ? wdata_p1_q : wdata_q;
        cm_strb = (WR_PIPE != 0) ? wstrb_p1_q : wstrb_q;

        regs_d    = regs_q;
        wr_strobe = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (cm_vld && (cm_idx == IDX_W'(i))) begin
                wr_strobe[i] = |cm_strb;
                for (int k = 0; k < BYTES; k++) begin
                    if (cm_strb[k]) regs_d[i*DATA_W + k*8 +: 8] = cm_data[k*8 +: 8];
                end
            end
        end

        bvalid_d = (bvalid_q & ~b_hs) | cm_vld;
        bresp_d  = bresp_q;
        if (cm_vld) bresp_d = ({1'b0, cm_idx} < NREGS_C) ? RESP_OKAY : RESP_DECERR;

        // Read path: the register is sampled on the request cycle, before any same-cycle commit lands.
        ar_hs     = arvalid & ~ar_set_q;
        r_hs      = rvalid_q & rready;
        rd_req    = ar_set_q & ~rd_done_q;
        ar_set_d  = (ar_set_q | ar_hs) & ~r_hs;
        rd_done_d = (rd_done_q | rd_req) & ~r_hs;
        raddr_d   = ar_hs ? araddr : raddr_q;

        rd_word = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (raddr_q == IDX_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
        end
        rd_resp = ({1'b0, raddr_q} < NREGS_C) ? RESP_OKAY : RESP_DECERR;

        rack_p1_d  = rd_req;
        rdata_p1_d = rd_word;
        rresp_p1_d = rd_resp;

        ra_vld  = (RD_PIPE != 0) ? rack_p1_q  : rd_req;
        ra_data = (RD_PIPE != 0) ? rdata_p1_q : rd_word;
        ra_resp = (RD_PIPE != 0) ? rresp_p1_q : rd_resp;

        rvalid_d = (rvalid_q & ~r_hs) | ra_vld;
        rdata_d  = ra_vld ? ra_data : rdata_q;
        rresp_d  = ra_vld ? ra_resp : rresp_q;
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            aw_set_q   <= 1'b0;
            w_set_q    <= 1'b0;
            wr_done_q  <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wreq_p1_q  <= 1'b0;
            widx_p1_q  <= '0;
            wdata_p1_q <= '0;
            wstrb_p1_q <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            regs_q     <= '0;
            ar_set_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            raddr_q    <= '0;
            rack_p1_q  <= 1'b0;
            rdata_p1_q <= '0;
            rresp_p1_q <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            aw_set_q   <= aw_set_d;
            w_set_q    <= w_set_d;
            wr_done_q  <= wr_done_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wreq_p1_q  <= wreq_p1_d;
            widx_p1_q  <= widx_p1_d;
            wdata_p1_q <= wdata_p1_d;
            wstrb_p1_q <= wstrb_p1_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            ar_set_q   <= ar_set_d;
            rd_done_q  <= rd_done_d;
            raddr_q    <= raddr_d;
            rack_p1_q  <= rack_p1_d;
            rdata_p1_q <= rdata_p1_d;
            rresp_p1_q <= rresp_p1_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // No commit is reported while reset is being applied.
    assign wr_strobe_o = wr_strobe & {NREGS{areset_n}};
    assign regs_o      = regs_q;
    assign awready     = ~aw_set_q;
    assign wready      = ~w_set_q;
    assign bvalid      = bvalid_q;
    assign bresp       = bresp_q;
    assign arready     = ~ar_set_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign rresp       = rresp_q;

endmodule
